// File: rtl/seven_segment_pkg.sv
// Segment patterns for a common seven-segment-plus-dot display.
// Bit 7 = a ... bit 1 = g, bit 0 = decimal point; all active-high.
package seven_segment_pkg;

  localparam logic [7:0] seg_0 = 8'hFC;
  localparam logic [7:0] seg_1 = 8'h60;
  localparam logic [7:0] seg_2 = 8'hDA;
  localparam logic [7:0] seg_3 = 8'hF2;
  localparam logic [7:0] seg_4 = 8'h66;
  localparam logic [7:0] seg_5 = 8'hB6;
  localparam logic [7:0] seg_6 = 8'hBE;
  localparam logic [7:0] seg_7 = 8'hE0;
  localparam logic [7:0] seg_8 = 8'hFE;
  localparam logic [7:0] seg_9 = 8'hF6;
  localparam logic [7:0] seg_a = 8'hEE;
  localparam logic [7:0] seg_b = 8'h3E;
  localparam logic [7:0] seg_c = 8'h9C;
  localparam logic [7:0] seg_d = 8'h7A;
  localparam logic [7:0] seg_e = 8'h9E;
  localparam logic [7:0] seg_f = 8'h8E;

  localparam logic [7:0] seg_blank    = 8'h00;
  localparam logic [7:0] seg_dot_mask = 8'h01;

endpackage

// File: rtl/hex_to_seven_segment.sv
// Combinational hex nibble to a..g segment decoder (dot excluded).
// Zero latency; no flow control.
module hex_to_seven_segment
  import seven_segment_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  logic [7:0] pattern;

  always_comb begin
    pattern = seg_blank;
    case (nibble_i)
      4'h0: pattern = seg_0;
      4'h1: pattern = seg_1;
      4'h2: pattern = seg_2;
      4'h3: pattern = seg_3;
      4'h4: pattern = seg_4;
      4'h5: pattern = seg_5;
      4'h6: pattern = seg_6;
      4'h7: pattern = seg_7;
      4'h8: pattern = seg_8;
      4'h9: pattern = seg_9;
      4'hA: pattern = seg_a;
      4'hB: pattern = seg_b;
      4'hC: pattern = seg_c;
      4'hD: pattern = seg_d;
      4'hE: pattern = seg_e;
      default: pattern = seg_f;
    endcase
  end

  assign seg_o = pattern[7:1];

endmodule

// File: rtl/seven_segment_scanner.sv
// Multiplexed seven-segment driver: one digit per strobe, value snapshotted per frame.
// Outputs registered 1 clk after a strobe edge; no backpressure, paced purely by strobe.
module seven_segment_scanner
  import seven_segment_pkg::*;
#(
  parameter int w_digit            = 4,
  parameter bit leading_zero_blank = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   strobe,
  input  logic [w_digit*4-1:0]   number,
  input  logic [w_digit-1:0]     dots,
  output logic [7:0]             abcdefgh,
  output logic [w_digit-1:0]     digit
);

  localparam int               w_idx    = (w_digit > 1) ? $clog2(w_digit) : 1;
  localparam logic [w_idx-1:0] idx_last = w_idx'(w_digit - 1);

  logic [w_idx-1:0]     idx_q, idx_d;
  logic [w_digit*4-1:0] snap_number_q, snap_number_d;
  logic [w_digit-1:0]   snap_dots_q, snap_dots_d;
  logic [7:0]           seg_q, seg_d;
  logic [w_digit-1:0]   digit_q, digit_d;

  logic [3:0]           nibble;
  logic [6:0]           seg7;
  logic [w_digit:0]     zero_from;
  logic                 blank;

  // Scan position and frame snapshot; the snapshot only reloads when wrapping to digit 0.
  always_comb begin
    idx_d         = idx_q;
    snap_number_d = snap_number_q;
    snap_dots_d   = snap_dots_q;
    if (strobe) begin
      if (idx_q == idx_last) begin
        idx_d         = '0;
        snap_number_d = number;
        snap_dots_d   = dots;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end

    // zero_from[k]: nibbles k..w_digit-1 of the next snapshot are all zero.
    zero_from          = '0;
    zero_from[w_digit] = 1'b1;
    for (int k = w_digit - 1; k >= 0; k--) begin
      zero_from[k] = zero_from[k+1] && (snap_number_d[4*k +: 4] == 4'h0);
    end

    nibble = snap_number_d[{idx_d, 2'b00} +: 4];
    blank  = leading_zero_blank && (idx_d != '0) && zero_from[idx_d];
  end

  hex_to_seven_segment u_hex (
    .nibble_i (nibble),
    .seg_o    (seg7)
  );

  always_comb begin
    seg_d   = seg_q;
    digit_d = digit_q;
    if (strobe) begin
      seg_d   = (blank ? seg_blank : {seg7, 1'b0})
              | (snap_dots_d[idx_d] ? seg_dot_mask : seg_blank);
      digit_d = w_digit'(1) << idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q         <= idx_last;
      snap_number_q <= '0;
      snap_dots_q   <= '0;
      seg_q         <= seg_blank;
      digit_q       <= '0;
    end else begin
      idx_q         <= idx_d;
      snap_number_q <= snap_number_d;
      snap_dots_q   <= snap_dots_d;
      seg_q         <= seg_d;
      digit_q       <= digit_d;
    end
  end

  assign abcdefgh = seg_q;
  assign digit    = digit_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed bench for seven_segment_scanner: a plain instance and a leading-zero-blanking
// instance share all inputs; expected segment/digit values are hand-computed constants.
module tb_seven_segment_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic        strobe;
  logic [15:0] number;
  logic [3:0]  dots;
  logic [7:0]  seg_a, seg_b;
  logic [3:0]  dig_a, dig_b;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  seven_segment_scanner #(.w_digit(4), .leading_zero_blank(1'b0)) dut (
    .clk(clk), .rst(rst), .strobe(strobe), .number(number), .dots(dots),
    .abcdefgh(seg_a), .digit(dig_a)
  );

  seven_segment_scanner #(.w_digit(4), .leading_zero_blank(1'b1)) dut_lzb (
    .clk(clk), .rst(rst), .strobe(strobe), .number(number), .dots(dots),
    .abcdefgh(seg_b), .digit(dig_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Compare both instances: same digit select, own segment expectation each.
  task automatic expect_out(input string tag, input logic [3:0] d,
                            input logic [7:0] s_plain, input logic [7:0] s_lzb);
    check({tag, ".dig"},     32'(dig_a), 32'(d));
    check({tag, ".seg"},     32'(seg_a), 32'(s_plain));
    check({tag, ".dig_lzb"}, 32'(dig_b), 32'(d));
    check({tag, ".seg_lzb"}, 32'(seg_b), 32'(s_lzb));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; strobe = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // One strobe pulse: outputs must not move before the edge, then show the new digit.
  task automatic pulse(input string tag, input logic [3:0] d,
                       input logic [7:0] s_plain, input logic [7:0] s_lzb);
    logic [7:0] prev_a;
    prev_a = seg_a;
    strobe = 1'b1;
    #3;
    check({tag, ".pre"}, 32'(seg_a), 32'(prev_a));
    tick();
    strobe = 1'b0;
    expect_out(tag, d, s_plain, s_lzb);
  endtask

  logic [3:0] exp_dig [4];
  logic [7:0] exp_seg [4];

  initial begin
    rst = 1'b1; strobe = 1'b0; number = '0; dots = '0;

    // Reset state and idle with no strobe.
    do_reset();
    expect_out("reset", 4'b0000, 8'h00, 8'h00);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle.dig", 32'(dig_a), 32'h0);
      check("idle.seg", 32'(seg_a), 32'h0);
    end

    // Normal scan of 12AF, strobe every 5 cycles, holding between strobes.
    number = 16'h12AF; dots = 4'b0000;
    exp_dig = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    exp_seg = '{8'h8E, 8'hEE, 8'hDA, 8'h60};
    for (int s = 0; s < 5; s++) begin
      pulse($sformatf("scan%0d", s + 1), exp_dig[s % 4], exp_seg[s % 4], exp_seg[s % 4]);
      for (int h = 0; h < 4; h++) tick();
      check("scan.hold", 32'(seg_a), 32'(exp_seg[s % 4]));
    end

    // Mid-frame number change must not affect the current frame.
    do_reset();
    number = 16'h12AF;
    pulse("snap1", 4'b0001, 8'h8E, 8'h8E);
    pulse("snap2", 4'b0010, 8'hEE, 8'hEE);
    number = 16'h0000;
    pulse("snap3", 4'b0100, 8'hDA, 8'hDA);
    pulse("snap4", 4'b1000, 8'h60, 8'h60);
    pulse("snap5", 4'b0001, 8'hFC, 8'hFC);

    // Leading-zero blanking with dot on a blanked digit.
    do_reset();
    number = 16'h0030; dots = 4'b1000;
    pulse("lzb0", 4'b0001, 8'hFC, 8'hFC);
    pulse("lzb1", 4'b0010, 8'hF2, 8'hF2);
    pulse("lzb2", 4'b0100, 8'hFC, 8'h00);
    pulse("lzb3", 4'b1000, 8'hFD, 8'h01);

    // Strobe held high: advances every cycle.
    do_reset();
    number = 16'h4321; dots = 4'b0000;
    exp_seg = '{8'h60, 8'hDA, 8'hF2, 8'h66};
    strobe = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      expect_out($sformatf("hold%0d", i), 4'(1 << (i % 4)), exp_seg[i % 4], exp_seg[i % 4]);
    end
    strobe = 1'b0;

    // Reset colliding with strobe mid-frame, then a fresh frame.
    do_reset();
    number = 16'h5678;
    pulse("mid0", 4'b0001, 8'hFE, 8'hFE);
    pulse("mid1", 4'b0010, 8'hE0, 8'hE0);
    pulse("mid2", 4'b0100, 8'hBE, 8'hBE);
    rst = 1'b1; strobe = 1'b1;
    tick();
    rst = 1'b0; strobe = 1'b0;
    expect_out("rstwin", 4'b0000, 8'h00, 8'h00);
    tick();
    expect_out("rsthold", 4'b0000, 8'h00, 8'h00);
    number = 16'h000D; dots = 4'b0001;
    pulse("fresh", 4'b0001, 8'h7B, 8'h7B);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
